// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors and FSM state encoding.
// Intended for reuse by both the buffered transmitter and a future receiver.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Wide enough to index up to 8 data bits or 2 stop bits
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data.
// Ports: clk, rst (sync, active-high); wr_en/wr_data push; rd_en pops the head into
// rd_data on the next edge; full/empty/count are registered status.
// A write while full is dropped even if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CNT_W-1:0] count_next;

    // Accept/pop qualification uses the registered flags only
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serialiser producing start / data (LSB first) /
// optional parity / stop frames at a runtime-programmable clocks-per-bit.
// Ports: clk, rst (sync, active-high); divisor (clocks per bit, <2 treated as 2);
// wr_en/wr_data queue a byte; full/count/overflow report FIFO status;
// busy = frame in progress or data queued; out = registered serial line (idle high).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIV_W-1:0]       divisor,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   out
);

    localparam int unsigned BIT_W = BIT_CNT_W;

    uart_state_e          state, state_next;
    logic [DIV_W-1:0]     div_q, div_next;
    logic [DIV_W-1:0]     clk_cnt, clk_cnt_next;
    logic [BIT_W-1:0]     bit_q, bit_next;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic                 par_q, par_next;
    logic                 out_next;
    logic                 busy_next;
    logic                 pop_c;
    logic                 bit_done_c;
    logic [DIV_W-1:0]     div_clamp_c;
    logic [7:0]           fifo_data;
    logic                 fifo_empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_c),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Divisor is sampled only when a frame is launched
    always_comb begin
        div_clamp_c = (divisor < DIV_W'(2)) ? DIV_W'(2) : divisor;
        bit_done_c  = (clk_cnt == div_q - DIV_W'(1));
    end

    // Next-state, counters and line value; out is the registered image of the current state
    always_comb begin
        state_next   = state;
        div_next     = div_q;
        clk_cnt_next = clk_cnt + DIV_W'(1);
        bit_next     = bit_q;
        shift_next   = shift_q;
        par_next     = par_q;
        out_next     = 1'b1;
        pop_c        = 1'b0;
        busy_next    = (state != ST_IDLE) || !fifo_empty;

        case (state)
            ST_IDLE: begin
                clk_cnt_next = '0;
                bit_next     = '0;
                if (!fifo_empty) begin
                    pop_c      = 1'b1;
                    div_next   = div_clamp_c;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                out_next = 1'b0;
                // Popped byte is valid in rd_data for the whole start bit
                if (bit_done_c) begin
                    clk_cnt_next = '0;
                    shift_next   = fifo_data[DATA_BITS-1:0];
                    par_next     = (PARITY == PAR_ODD) ? ~^fifo_data[DATA_BITS-1:0]
                                                       :  ^fifo_data[DATA_BITS-1:0];
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                out_next = shift_q[0];
                if (bit_done_c) begin
                    clk_cnt_next = '0;
                    shift_next   = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                out_next = par_q;
                if (bit_done_c) begin
                    clk_cnt_next = '0;
                    state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done_c) begin
                    clk_cnt_next = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_next = '0;
                        // Back-to-back frames: launch the next one with no idle gap
                        if (!fifo_empty) begin
                            pop_c      = 1'b1;
                            div_next   = div_clamp_c;
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_next = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_q    <= DIV_W'(2);
            clk_cnt  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            out      <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            div_q    <= div_next;
            clk_cnt  <= clk_cnt_next;
            bit_q    <= bit_next;
            shift_q  <= shift_next;
            par_q    <= par_next;
            out      <= out_next;
            busy     <= busy_next;
            overflow <= wr_en && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered: four instances cover
// 8N1/DEPTH16, 7E2, 7O2 and 8N1/DEPTH4.
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: defaults (8N1, DEPTH 16)
    logic [15:0] divisor_a;
    logic        wr_en_a;
    logic [7:0]  wr_data_a;
    logic        full_a, overflow_a, busy_a, out_a;
    logic [4:0]  count_a;

    // Instance E: 7 data bits, even parity, 2 stop bits
    logic [15:0] divisor_e;
    logic        wr_en_e;
    logic [7:0]  wr_data_e;
    logic        full_e, overflow_e, busy_e, out_e;
    logic [4:0]  count_e;

    // Instance O: 7 data bits, odd parity, 2 stop bits
    logic [15:0] divisor_o;
    logic        wr_en_o;
    logic [7:0]  wr_data_o;
    logic        full_o, overflow_o, busy_o, out_o;
    logic [4:0]  count_o;

    // Instance D: DEPTH 4
    logic [15:0] divisor_d;
    logic        wr_en_d;
    logic [7:0]  wr_data_d;
    logic        full_d, overflow_d, busy_d, out_d;
    logic [2:0]  count_d;

    uart_tx_buffered dut_a (
        .clk(clk), .rst(rst), .divisor(divisor_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .full(full_a), .count(count_a), .overflow(overflow_a), .busy(busy_a), .out(out_a)
    );

    uart_tx_buffered #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_e (
        .clk(clk), .rst(rst), .divisor(divisor_e), .wr_en(wr_en_e), .wr_data(wr_data_e),
        .full(full_e), .count(count_e), .overflow(overflow_e), .busy(busy_e), .out(out_e)
    );

    uart_tx_buffered #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_o (
        .clk(clk), .rst(rst), .divisor(divisor_o), .wr_en(wr_en_o), .wr_data(wr_data_o),
        .full(full_o), .count(count_o), .overflow(overflow_o), .busy(busy_o), .out(out_o)
    );

    uart_tx_buffered #(.DEPTH(4)) dut_d (
        .clk(clk), .rst(rst), .divisor(divisor_d), .wr_en(wr_en_d), .wr_data(wr_data_d),
        .full(full_d), .count(count_d), .overflow(overflow_d), .busy(busy_d), .out(out_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic out_of(input int sel);
        case (sel)
            0:       return out_a;
            1:       return out_e;
            2:       return out_o;
            default: return out_d;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_e;
            2:       return busy_o;
            default: return busy_d;
        endcase
    endfunction

    // Checks one frame sample-by-sample; the first 'skip' clocks are assumed already elapsed.
    // At sample 'chg_at' the instance-A divisor is rewritten to emulate a mid-frame change.
    task automatic expect_frame(input int sel, input int div, input logic [7:0] d,
                                input int nb, input bit has_par, input logic par_bit,
                                input int stops, input int skip, input int chg_at,
                                input logic [15:0] chg_val, input string tag);
        logic bits[$];
        int   idx;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (has_par) bits.push_back(par_bit);
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        idx = 0;
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < div; k++) begin
                if (idx >= skip) begin
                    tick();
                    check({tag, "_out"}, 32'(out_of(sel)), 32'(bits[b]));
                    check({tag, "_busy"}, 32'(busy_of(sel)), 32'd1);
                    if (idx == chg_at) divisor_a = chg_val;
                end
                idx++;
            end
        end
    endtask

    int bad;

    initial begin
        rst = 1'b1;
        divisor_a = 16'd4;   wr_en_a = 1'b0; wr_data_a = 8'h00;
        divisor_e = 16'd3;   wr_en_e = 1'b0; wr_data_e = 8'h00;
        divisor_o = 16'd3;   wr_en_o = 1'b0; wr_data_o = 8'h00;
        divisor_d = 16'd434; wr_en_d = 1'b0; wr_data_d = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_a", 32'(out_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_full_a", 32'(full_a), 32'd0);
        check("rst_count_a", 32'(count_a), 32'd0);
        check("rst_ovf_a", 32'(overflow_a), 32'd0);
        check("rst_out_d", 32'(out_d), 32'd1);
        check("rst_count_d", 32'(count_d), 32'd0);
        tick();

        // Test 1: 8N1, div 4, 0xA5
        wr_en_a = 1'b1; wr_data_a = 8'hA5;
        tick();
        wr_en_a = 1'b0;
        check("t1_count", 32'(count_a), 32'd1);
        check("t1_idle0", 32'(out_a), 32'd1);
        tick();
        check("t1_idle1", 32'(out_a), 32'd1);
        check("t1_busy_pre", 32'(busy_a), 32'd1);
        expect_frame(0, 4, 8'hA5, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t1");
        tick();
        check("t1_busy_end", 32'(busy_a), 32'd0);
        check("t1_out_end", 32'(out_a), 32'd1);

        // Test 2: two back-to-back bytes, no gap
        wr_en_a = 1'b1; wr_data_a = 8'h55;
        tick();
        wr_data_a = 8'h0F;
        tick();
        wr_en_a = 1'b0;
        expect_frame(0, 4, 8'h55, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t2a");
        expect_frame(0, 4, 8'h0F, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t2b");
        tick();
        check("t2_busy_end", 32'(busy_a), 32'd0);

        // Test 3: 7E2 and 7O2, div 3, 0x83 (bit 7 ignored, parity over 0000011)
        wr_en_e = 1'b1; wr_data_e = 8'h83;
        tick();
        wr_en_e = 1'b0;
        tick();
        expect_frame(1, 3, 8'h83, 7, 1'b1, 1'b0, 2, 0, -1, 16'd0, "t3e");
        tick();
        check("t3e_busy_end", 32'(busy_e), 32'd0);
        check("t3e_out_end", 32'(out_e), 32'd1);
        wr_en_o = 1'b1; wr_data_o = 8'h83;
        tick();
        wr_en_o = 1'b0;
        tick();
        expect_frame(2, 3, 8'h83, 7, 1'b1, 1'b1, 2, 0, -1, 16'd0, "t3o");
        tick();
        check("t3o_busy_end", 32'(busy_o), 32'd0);

        // Test 4: DEPTH 4, six consecutive writes, sixth dropped
        wr_en_d = 1'b1; wr_data_d = 8'h11;
        tick();
        wr_data_d = 8'h22;
        tick();
        wr_data_d = 8'h33;
        tick();
        wr_data_d = 8'h44;
        tick();
        check("t4_count3", 32'(count_d), 32'd3);
        check("t4_notfull", 32'(full_d), 32'd0);
        wr_data_d = 8'h55;
        tick();
        check("t4_full", 32'(full_d), 32'd1);
        check("t4_count4", 32'(count_d), 32'd4);
        check("t4_noovf", 32'(overflow_d), 32'd0);
        wr_data_d = 8'h66;
        tick();
        wr_en_d = 1'b0;
        check("t4_ovf", 32'(overflow_d), 32'd1);
        check("t4_count_hold", 32'(count_d), 32'd4);
        tick();
        check("t4_ovf_pulse", 32'(overflow_d), 32'd0);
        expect_frame(3, 434, 8'h11, 8, 1'b0, 1'b0, 1, 5, -1, 16'd0, "t4f1");
        expect_frame(3, 434, 8'h22, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t4f2");
        expect_frame(3, 434, 8'h33, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t4f3");
        expect_frame(3, 434, 8'h44, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t4f4");
        expect_frame(3, 434, 8'h55, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t4f5");
        tick();
        check("t4_busy_end", 32'(busy_d), 32'd0);
        check("t4_count_end", 32'(count_d), 32'd0);
        bad = 0;
        repeat (1000) begin
            tick();
            if (out_d !== 1'b1) bad++;
        end
        check("t4_no_sixth", 32'(bad), 32'd0);

        // Test 6a: divisor 0 behaves as 2
        divisor_a = 16'd0;
        wr_en_a = 1'b1; wr_data_a = 8'h3C;
        tick();
        wr_en_a = 1'b0;
        tick();
        expect_frame(0, 2, 8'h3C, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t6a");
        tick();
        check("t6a_busy_end", 32'(busy_a), 32'd0);

        // Test 6b: divisor 4 -> 8 during the first frame
        divisor_a = 16'd4;
        wr_en_a = 1'b1; wr_data_a = 8'h96;
        tick();
        wr_data_a = 8'h69;
        tick();
        wr_en_a = 1'b0;
        expect_frame(0, 4, 8'h96, 8, 1'b0, 1'b0, 1, 0, 10, 16'd8, "t6b1");
        expect_frame(0, 8, 8'h69, 8, 1'b0, 1'b0, 1, 0, -1, 16'd0, "t6b2");
        tick();
        check("t6b_busy_end", 32'(busy_a), 32'd0);

        // Test 5: reset during data bit 3 with two bytes queued
        divisor_a = 16'd4;
        wr_en_a = 1'b1; wr_data_a = 8'hA5;
        tick();
        wr_data_a = 8'h3C;
        tick();
        wr_data_a = 8'h0F;
        tick();
        wr_en_a = 1'b0;
        check("t5_start", 32'(out_a), 32'd0);
        repeat (17) tick();
        check("t5_bit3", 32'(out_a), 32'd0);
        check("t5_queued", 32'(count_a), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_out", 32'(out_a), 32'd1);
        check("t5_busy", 32'(busy_a), 32'd0);
        check("t5_count", 32'(count_a), 32'd0);
        check("t5_full", 32'(full_a), 32'd0);
        bad = 0;
        repeat (1000) begin
            tick();
            if (out_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("t5_mark_hold", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
